// File: rtl/sound_wave_ram.sv
// ---------------------------------------------------------------------------
// sound_wave_ram
//
// 16 x 8 wave pattern RAM shared between the CPU and the channel-3 sample
// fetcher. The channel pulls one byte per pointer advance into a sample
// buffer (wave_d). While the channel plays, CPU accesses are redirected to
// the channel's current byte address.
//
// Build option:
//   SOUND_WAVE_DMG_BUG_EN  defined   -> DMG behaviour: while playing, CPU
//                                       access only succeeds for WINDOW
//                                       cycles after a sample fetch; outside
//                                       that window writes are dropped and
//                                       reads return 0xFF.
//                          undefined -> CGB behaviour: while playing, CPU
//                                       access always succeeds (no window
//                                       counter is built).
//
// Parameters:
//   WINDOW      access window length in clk cycles after a fetch (1..3)
//
// Ports:
//   clk         CPU clock, all state updates on the rising edge
//   rst         synchronous active-high reset (RAM contents are kept)
//   a           CPU byte address (0xFF30-0xFF3F -> 0-15)
//   din         CPU write data
//   wr          CPU write strobe
//   rd          CPU read strobe
//   dout        CPU read data, registered, holds when not reading
//   ch_on       channel 3 playing
//   wave_a      channel byte address (sample pointer[4:1])
//   wave_fetch  one-cycle pulse: channel needs a new sample byte
//   wave_d      sample buffer presented to the channel
// ---------------------------------------------------------------------------
module sound_wave_ram #(
    parameter int WINDOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [7:0] din,
    input  logic       wr,
    input  logic       rd,
    output logic [7:0] dout,
    input  logic       ch_on,
    input  logic [3:0] wave_a,
    input  logic       wave_fetch,
    output logic [7:0] wave_d
);

    // Reject an out-of-range window length at elaboration.
    generate
        if (WINDOW < 1 || WINDOW > 3) begin : g_window_range
            $error("sound_wave_ram: WINDOW must be in 1..3");
        end
    endgenerate

    logic [7:0] ram_q [16];
    logic [7:0] buf_q;
    logic [7:0] buf_d;
    logic [7:0] dout_q;
    logic [7:0] dout_d;
    logic       win_open_s;
    logic [3:0] eff_a_s;
    logic       ram_we_s;

`ifdef SOUND_WAVE_DMG_BUG_EN
    localparam logic [1:0] WIN_LOAD = 2'(WINDOW);

    logic [1:0] win_q;
    logic [1:0] win_d;

    // Window counter next state: cleared while idle, reloaded on fetch,
    // then counts down and sticks at zero.
    always_comb begin
        win_d = win_q;
        if (!ch_on) begin
            win_d = 2'd0;
        end else if (wave_fetch) begin
            win_d = WIN_LOAD;
        end else if (win_q != 2'd0) begin
            win_d = win_q - 2'd1;
        end else begin
            win_d = win_q;
        end
    end

    // Window counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= 2'd0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_open_s = (win_q != 2'd0);
`else
    assign win_open_s = 1'b1;
`endif

    // While playing, the CPU only ever reaches the byte the channel is on.
    assign eff_a_s  = ch_on ? wave_a : a;
    assign ram_we_s = wr & (~ch_on | win_open_s);

    // Sample buffer and CPU read data next state.
    always_comb begin
        buf_d  = buf_q;
        dout_d = dout_q;
        // The RAM write lands at the same edge, so a coincident fetch
        // naturally captures the pre-write byte.
        if (wave_fetch) begin
            buf_d = ram_q[wave_a];
        end else begin
            buf_d = buf_q;
        end
        // A simultaneous write wins; the read is dropped and dout holds.
        if (rd && !wr) begin
            if (!ch_on) begin
                dout_d = ram_q[a];
            end else if (win_open_s) begin
                dout_d = buf_q;
            end else begin
                dout_d = 8'hFF;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // Sample buffer and read data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= 8'h00;
            dout_q <= 8'hFF;
        end else begin
            buf_q  <= buf_d;
            dout_q <= dout_d;
        end
    end

    // RAM array: no reset, writes suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && ram_we_s) begin
            ram_q[eff_a_s] <= din;
        end
    end

    assign dout   = dout_q;
    assign wave_d = buf_q;

endmodule

// File: doc/sound_wave_ram.md
SOUND_WAVE_RAM -- requirements
Module: sound_wave_ram

Interface
REQ-001 The module SHALL have parameter WINDOW, default 2, giving the number of clk cycles after a sample fetch during which CPU access to a playing channel succeeds (range 1..3).
REQ-002 The module SHALL have the port clk, input, 1 bit: main CPU clock; all state updates on its rising edge.
REQ-003 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have the port a, input, 4 bits: CPU byte address within wave RAM (0xFF30-0xFF3F maps to 0-15).
REQ-005 The module SHALL have the port din, input, 8 bits: CPU write data.
REQ-006 The module SHALL have the port wr, input, 1 bit: CPU write strobe, one access per cycle high.
REQ-007 The module SHALL have the port rd, input, 1 bit: CPU read strobe.
REQ-008 The module SHALL have the port dout, output, 8 bits: CPU read data, registered.
REQ-009 The module SHALL have the port ch_on, input, 1 bit: channel 3 playing.
REQ-010 The module SHALL have the port wave_a, input, 4 bits: channel byte address (sample pointer[4:1]).
REQ-011 The module SHALL have the port wave_fetch, input, 1 bit: one-cycle pulse when the channel advances its pointer and needs a new byte.
REQ-012 The module SHALL have the port wave_d, output, 8 bits: sample byte buffer presented to the channel, high nibble first.

Function
REQ-013 Storage SHALL be 16 x 8 bits; contents are not altered by rst.
REQ-014 On wave_fetch, the sample buffer SHALL load ram[wave_a] at the next edge; wave_d is the buffer and changes only on fetch or rst.
REQ-015 With ch_on=0, wr SHALL write din to ram[a], and rd SHALL load ram[a] into dout next cycle (1-cycle latency).
REQ-016 With ch_on=1 and the access window open, the CPU address SHALL be replaced by wave_a: wr writes ram[wave_a] and rd returns the sample buffer contents.
REQ-017 With ch_on=1 and the window closed, wr SHALL be ignored and rd SHALL return 0xFF.
REQ-018 Window counter: wave_fetch loads WINDOW, otherwise decrements to 0 and saturates; the window is open while the counter is non-zero, starting the cycle after the fetch.
REQ-019 When wr and wave_fetch coincide on the same effective address, the buffer SHALL receive the pre-write byte and the RAM SHALL receive din.
REQ-020 A CPU write SHALL never update the sample buffer directly; the new value is seen only on a later fetch.
REQ-021 When rd and wr are both high, wr SHALL take priority and dout SHALL hold its previous value.
REQ-022 When ch_on falls, the window counter SHALL clear to 0 and direct addressing SHALL resume the next cycle.
REQ-023 dout SHALL hold its last value when rd is low.

Reset
REQ-024 While rst is high at a clk edge, the buffer SHALL clear to 0x00, the window counter to 0, and dout to 0xFF; RAM is untouched and wave_fetch/wr are ignored.
REQ-025 Reset asserted mid-window SHALL close the window at that edge.

Configuration
REQ-026 The macro SOUND_WAVE_DMG_BUG_EN SHALL control the access-window behaviour (DMG behaviour).
REQ-027 With SOUND_WAVE_DMG_BUG_EN defined, REQ-016 to REQ-018 apply as written.
REQ-028 Without SOUND_WAVE_DMG_BUG_EN, the window SHALL be treated as always open while ch_on=1 (CGB behaviour), the window counter SHALL be absent, and REQ-017 SHALL not apply.

Verification
REQ-029 ch_on=0, write 0x5A to a=3, read a=3 -> dout=0x5A one cycle later; write 0x00..0xF0 to all addresses and read back each value intact.
REQ-030 ch_on=1, RAM[7]=0x9C, wave_a=7, pulse wave_fetch -> wave_d=0x9C next cycle; a read of a=0 within 2 cycles -> 0x9C; a read 4 cycles after the fetch -> 0xFF (macro defined) or 0x9C (undefined).
REQ-031 ch_on=1, window open, wave_a=2, write 0x11 with a=9 -> RAM[2]=0x11 and RAM[9] unchanged; the same write outside the window (macro defined) -> RAM[2] unchanged.
REQ-032 Same-cycle write 0x77 and fetch at wave_a=5 with RAM[5]=0x33 -> wave_d=0x33 and RAM[5]=0x77; a second fetch -> wave_d=0x77.
REQ-033 rst pulsed mid-window with RAM[0]=0xAB -> wave_d=0x00, dout=0xFF, window closed; after reset, ch_on=0 and a read of a=0 -> 0xAB.
